// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, issues one fetch
// at a time over a variable-latency req/rsp interface and inserts NOP bubbles.
//
// imem handshake: a request transfers on a rising edge where imem_req_o and
// imem_ready_i are both high; imem_rvalid_i (one cycle, data on imem_rdata_i)
// answers the single outstanding request and has no back-pressure.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        PCWrite_i,
    input  logic        Stall_i,
    input  logic        Flush_i,
    input  logic [31:0] Branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] IFID_pc_o,
    output logic [31:0] IFID_instr_o,
    output logic        IFID_valid_o,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        deliver_ok;
    logic        deliver;
    logic [31:0] deliver_instr;

    assign deliver_ok = PCWrite_i & ~Stall_i & ~Flush_i;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        buf_d         = buf_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_valid_d  = ifid_valid_q;
        deliver       = 1'b0;
        deliver_instr = buf_q;

        if (Flush_i) begin
            // Redirect wins even over a stall; anything in flight becomes stale.
            ifid_pc_d    = 32'h0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            pc_d         = {Branch_target_i[31:2], 2'b00};
            unique case (state_q)
                S_REQ:   state_d = imem_ready_i ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_rvalid_i ? S_REQ : S_DROP;
                S_HOLD:  state_d = S_REQ;
                S_DROP:  state_d = imem_rvalid_i ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem_ready_i) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (deliver_ok) begin
                            deliver       = 1'b1;
                            deliver_instr = imem_rdata_i;
                            state_d       = S_REQ;
                        end else begin
                            buf_d   = imem_rdata_i;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (deliver_ok) begin
                        deliver = 1'b1;
                        state_d = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid_i) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase

            if (deliver) begin
                ifid_pc_d    = pc_q;
                ifid_instr_d = deliver_instr;
                ifid_valid_d = 1'b1;
                pc_d         = pc_q + 32'd4;
            end else if (!Stall_i) begin
                ifid_pc_d    = 32'h0;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            buf_q        <= 32'h0;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_req_o   = (state_q == S_REQ) & ~rst_i;
    assign imem_addr_o  = pc_q;
    assign IFID_pc_o    = ifid_pc_q;
    assign IFID_instr_o = ifid_instr_q;
    assign IFID_valid_o = ifid_valid_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random hazards/flushes/resets,
// checked each cycle against a transaction-level model of the fetch stage.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_write = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [1:0]  dbg_state;

    if_stage dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .PCWrite_i      (pc_write),
        .Stall_i        (stall),
        .Flush_i        (flush),
        .Branch_target_i(branch_target),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ready_i   (imem_ready),
        .imem_rvalid_i  (imem_rvalid),
        .imem_rdata_i   (imem_rdata),
        .IFID_pc_o      (ifid_pc),
        .IFID_instr_o   (ifid_instr),
        .IFID_valid_o   (ifid_valid),
        .dbg_state_o    (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // memory environment
    int          ready_mode = 1;   // 0 never, 1 always when idle, 2 random
    int          mem_lat = 0;
    logic [31:0] mem_salt = 32'h0;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = 32'h0;

    // reference model of the fetch stage
    logic [31:0] m_pc = 32'h0;
    logic        m_out = 1'b0;     // accepted request awaiting its response
    logic        m_stale = 1'b0;   // that response belongs to a squashed path
    logic        m_hold = 1'b0;    // fetched instruction parked, not yet delivered
    logic [31:0] m_buf = 32'h0;
    logic [31:0] m_ifid_pc = 32'h0;
    logic [31:0] m_ifid_instr = NOP;
    logic        m_ifid_valid = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_bubble();
        m_ifid_pc    = 32'h0;
        m_ifid_instr = NOP;
        m_ifid_valid = 1'b0;
    endtask

    // One clock cycle: drive memory, check fetch port, clock, update model, check IF/ID.
    task automatic step();
        logic        m_req, acc, got, have, dok;
        logic [31:0] acc_addr, ainstr;
        imem_rvalid = mem_busy && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_data : 32'hDEAD_BEEF;
        imem_ready  = !mem_busy && (ready_mode == 1 || (ready_mode == 2 && $urandom_range(0, 1) == 1));
        #1;
        m_req = !rst && !m_out && !m_hold;
        chk("imem_req", {31'h0, imem_req}, {31'h0, m_req});
        chk("imem_addr", imem_addr, m_pc);
        acc      = imem_req && imem_ready;
        acc_addr = imem_addr;
        @(posedge clk);
        if (rst) mem_busy = 1'b0;
        else if (imem_rvalid) mem_busy = 1'b0;
        else if (mem_busy) mem_cnt--;
        if (acc && !rst) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_data = (acc_addr + 32'h100) ^ mem_salt;
        end

        dok  = pc_write && !stall && !flush;
        got  = m_out && imem_rvalid;
        have = 1'b0;
        ainstr = 32'h0;
        if (rst) begin
            m_pc = 32'h0; m_out = 0; m_stale = 0; m_hold = 0; m_buf = 32'h0;
            model_bubble();
        end else if (flush) begin
            model_bubble();
            m_pc   = {branch_target[31:2], 2'b00};
            m_hold = 1'b0;
            if (got) begin
                m_out = 1'b0; m_stale = 1'b0;
            end else if (m_out) begin
                m_stale = 1'b1;
            end else if (m_req && imem_ready) begin
                m_out = 1'b1; m_stale = 1'b1;
            end
        end else begin
            if (m_hold) begin
                have = 1'b1; ainstr = m_buf;
            end else if (got) begin
                m_out = 1'b0;
                if (!m_stale) begin have = 1'b1; ainstr = imem_rdata; end
                m_stale = 1'b0;
            end else if (m_req && imem_ready) begin
                m_out = 1'b1; m_stale = 1'b0;
            end
            if (have && dok) begin
                m_ifid_pc = m_pc; m_ifid_instr = ainstr; m_ifid_valid = 1'b1;
                m_pc   = m_pc + 32'd4;
                m_hold = 1'b0;
            end else begin
                if (have) begin m_hold = 1'b1; m_buf = ainstr; end
                if (!stall) model_bubble();
            end
        end
        #1;
        chk("ifid_pc", ifid_pc, m_ifid_pc);
        chk("ifid_instr", ifid_instr, m_ifid_instr);
        chk("ifid_valid", {31'h0, ifid_valid}, {31'h0, m_ifid_valid});
    endtask

    task automatic set_ctrl(input logic pw, input logic st, input logic fl, input logic [31:0] tgt);
        pc_write = pw; stall = st; flush = fl; branch_target = tgt;
    endtask

    initial begin
        int seen_new;
        // reset
        rst = 1'b1;
        step(); step();
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        rst = 1'b0;

        // zero-wait memory: one instruction every other cycle
        ready_mode = 1; mem_lat = 0;
        exp_q = '{32'h100, 32'h104, 32'h108};
        for (int i = 0; i < 6; i++) begin
            step();
            chk("zw_valid_slot", {31'h0, ifid_valid}, (i % 2 == 1) ? 32'h1 : 32'h0);
            if (ifid_valid) begin
                got_q.push_back(ifid_instr);
                chk("zw_pc", ifid_pc, 32'(4 * (i / 2)));
            end
        end
        chk("zw_count", got_q.size(), 32'd3);
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk("zw_instr", got_q.pop_front(), exp_q.pop_front());

        // memory not ready for 3 cycles
        ready_mode = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nr_addr", imem_addr, 32'hC);
            chk("nr_bubble", {31'h0, ifid_valid}, 32'h0);
        end
        ready_mode = 1;
        step();
        chk("nr_first_bubble", {31'h0, ifid_valid}, 32'h0);
        step();
        chk("nr_valid", {31'h0, ifid_valid}, 32'h1);
        chk("nr_pc", ifid_pc, 32'hC);
        chk("nr_instr", ifid_instr, 32'h10C);

        // stall for 2 cycles while the response arrives
        set_ctrl(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_hold_pc", ifid_pc, 32'hC);
            chk("stall_hold_valid", {31'h0, ifid_valid}, 32'h1);
        end
        set_ctrl(1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("stall_release_pc", ifid_pc, 32'h10);
        chk("stall_release_instr", ifid_instr, 32'h110);
        chk("stall_pc_once", imem_addr, 32'h14);

        // flush in the same cycle the request is accepted, with stall high
        mem_lat = 2;
        set_ctrl(1'b0, 1'b1, 1'b1, 32'h203);
        step();
        chk("flush_valid", {31'h0, ifid_valid}, 32'h0);
        chk("flush_instr", ifid_instr, NOP);
        set_ctrl(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drop_no_valid", {31'h0, ifid_valid}, 32'h0);
        end
        chk("redirect_req", {31'h0, imem_req}, 32'h1);
        chk("redirect_addr", imem_addr, 32'h200);

        // flush while an instruction is parked
        mem_lat = 0;
        step();
        set_ctrl(1'b0, 1'b1, 1'b0, 32'h0);
        step();
        set_ctrl(1'b0, 1'b1, 1'b1, 32'h400);
        step();
        chk("hold_flush_valid", {31'h0, ifid_valid}, 32'h0);
        set_ctrl(1'b1, 1'b0, 1'b0, 32'h0);
        seen_new = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("hold_flush_no_old", {31'h0, ifid_valid && ifid_pc == 32'h200}, 32'h0);
            if (ifid_valid && ifid_pc == 32'h400) seen_new++;
        end
        chk("hold_flush_new_path", seen_new, 32'd1);

        // reset while waiting on a response
        mem_lat = 3;
        for (int i = 0; i < 10 && !(m_out && !m_stale); i++) step();
        chk("wait_reached", {31'h0, m_out && !m_stale}, 32'h1);
        rst = 1'b1;
        step();
        chk("rst_wait_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_wait_addr", imem_addr, 32'h0);
        chk("rst_wait_req", {31'h0, imem_req}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_release_req", {31'h0, imem_req}, 32'h1);

        // random traffic
        ready_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) set_ctrl(1'b0, 1'b1, 1'b0, 32'h0);
            else if (r == 2) set_ctrl(1'b0, 1'b0, 1'b0, 32'h0);
            else set_ctrl(1'b1, 1'b0, 1'b0, 32'h0);
            if ($urandom_range(0, 19) == 0) begin
                flush = 1'b1;
                branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            rst      = ($urandom_range(0, 199) == 0);
            mem_lat  = $urandom_range(0, 3);
            mem_salt = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
